// File: rtl/regfile_seq_pkg.sv
// Shared opcode, ALU-code, FSM-state and instruction-layout definitions for regfile_seq.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_WB   = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CL_NOP  = 2'd0,
        CL_ALU  = 2'd1,
        CL_HALT = 2'd2,
        CL_ILL  = 2'd3
    } op_class_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rsvd;
    } instr_t;

    // Decoded fields kept for the lifetime of one instruction.
    typedef struct packed {
        logic [2:0] alu_op;
        logic       uses_rs2;
        logic       writes_rd;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
    } meta_t;

endpackage

// File: rtl/regfile_seq_dec.sv
// Opcode decoder: classifies an opcode and derives ALU code and register usage.
// Latency: combinational.
// Backpressure: none.
module regfile_seq_dec
    import regfile_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] alu_op,
    output logic       uses_rs2,
    output logic       writes_rd
);

    always_comb begin
        op_class  = CL_ILL;
        alu_op    = ALU_ADD;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_NOP: op_class = CL_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                op_class  = CL_ALU;
                alu_op    = opcode[2:0] - 3'd1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_MOV: begin
                op_class  = CL_ALU;
                alu_op    = ALU_MOV;
                writes_rd = 1'b1;
            end
            OP_HALT: op_class = CL_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_seq.sv
// Register-file sequencer: steps each instruction through READ/EXEC/WB driving selects and enables.
// Latency: ALU ops retire 4 cycles after transfer start (IDLE..WB), NOP 2 cycles, illegal flagged next cycle.
// Backpressure: instr_ready is high only in IDLE; HALT holds it low until reset.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             ck,
    input  logic             res,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [2:0]       LSEL,
    output logic [2:0]       RSEL,
    output logic [2:0]       OSEL,
    output logic             LOUT,
    output logic             ROUT,
    output logic             OIN,
    output logic [2:0]       alu_op,
    output logic             alu_go,
    output logic             done,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    instr_t    in_f;
    op_class_t dec_class;
    logic [2:0] dec_alu;
    logic      dec_rs2;
    logic      dec_wr;
    logic      xfer;
    logic      unused_bits;

    state_t    state;
    state_t    state_nxt;
    meta_t     meta_q;
    logic      ready_en;
    logic      ill_q;

    assign in_f        = instr_t'(instr);
    assign unused_bits = ^in_f.rsvd;
    assign xfer        = instr_ready & instr_valid;

    regfile_seq_dec u_dec (
        .opcode    (in_f.opcode),
        .op_class  (dec_class),
        .alu_op    (dec_alu),
        .uses_rs2  (dec_rs2),
        .writes_rd (dec_wr)
    );

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    case (dec_class)
                        CL_ALU:  state_nxt = ST_READ;
                        CL_NOP:  state_nxt = ST_WB;
                        CL_HALT: state_nxt = ST_HALT;
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ready_en keeps instr_ready low while reset is held and until the first clock after release.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            meta_q   <= '0;
            ready_en <= 1'b0;
            ill_q    <= 1'b0;
            retired  <= '0;
        end else begin
            ready_en <= 1'b1;
            ill_q    <= xfer && (dec_class == CL_ILL);
            if (xfer) begin
                meta_q.alu_op    <= dec_alu;
                meta_q.uses_rs2  <= dec_rs2;
                meta_q.writes_rd <= dec_wr;
                meta_q.rd        <= in_f.rd;
                meta_q.rs1       <= in_f.rs1;
                meta_q.rs2       <= in_f.rs2;
            end
            if (state == ST_WB) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        instr_ready = ready_en && (state == ST_IDLE);
        halted      = (state == ST_HALT);
        illegal     = ill_q;
        LSEL        = 3'd0;
        RSEL        = 3'd0;
        OSEL        = 3'd0;
        LOUT        = 1'b0;
        ROUT        = 1'b0;
        OIN         = 1'b0;
        alu_op      = 3'd0;
        alu_go      = 1'b0;
        done        = 1'b0;
        case (state)
            ST_READ: begin
                LOUT = 1'b1;
                LSEL = meta_q.rs1;
                ROUT = meta_q.uses_rs2;
                RSEL = meta_q.uses_rs2 ? meta_q.rs2 : 3'd0;
            end
            ST_EXEC: begin
                alu_go = 1'b1;
                alu_op = meta_q.alu_op;
            end
            ST_WB: begin
                done = 1'b1;
                OIN  = meta_q.writes_rd;
                OSEL = meta_q.writes_rd ? meta_q.rd : 3'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Randomized scoreboard bench for regfile_seq plus directed halt, async-reset and counter-wrap cases.
module tb_regfile_seq;

    logic        ck = 1'b0;
    logic        res;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  LSEL, RSEL, OSEL, alu_op;
    logic        LOUT, ROUT, OIN, alu_go, done, illegal, halted;
    logic [15:0] retired;

    logic [15:0] instr4;
    logic        valid4, rdy4;
    logic [2:0]  LSEL4, RSEL4, OSEL4, alu_op4;
    logic        LOUT4, ROUT4, OIN4, alu_go4, done4, illegal4, halted4;
    logic [3:0]  ret4;

    always #5 ck = ~ck;

    regfile_seq u_dut (
        .ck(ck), .res(res), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .LSEL(LSEL), .RSEL(RSEL), .OSEL(OSEL), .LOUT(LOUT), .ROUT(ROUT), .OIN(OIN),
        .alu_op(alu_op), .alu_go(alu_go), .done(done), .illegal(illegal), .halted(halted),
        .retired(retired)
    );

    regfile_seq #(.CNT_W(4)) u_dut4 (
        .ck(ck), .res(res), .instr(instr4), .instr_valid(valid4), .instr_ready(rdy4),
        .LSEL(LSEL4), .RSEL(RSEL4), .OSEL(OSEL4), .LOUT(LOUT4), .ROUT(ROUT4), .OIN(OIN4),
        .alu_op(alu_op4), .alu_go(alu_go4), .done(done4), .illegal(illegal4), .halted(halted4),
        .retired(ret4)
    );

    localparam int EV_READ = 0, EV_EXEC = 1, EV_WB = 2, EV_ILL = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [2:0] a;
        logic [2:0] b;
        logic       c;
        logic [15:0] r;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   model_ret = 0;
    logic mon_en = 1'b0;
    logic mon4_en = 1'b0;

    always @(posedge ck) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int t, input logic [2:0] a, input logic [2:0] b,
                           input logic c, input logic [15:0] r);
        ev_t e;
        e.kind = kind; e.cyc = t; e.a = a; e.b = b; e.c = c; e.r = r;
        exp_q.push_back(e);
    endtask

    // Reference: what the sequencer must show for an instruction accepted on clock t.
    task automatic model(input logic [15:0] ins, input int t);
        int op;
        op = int'(ins[15:12]);
        if (op >= 1 && op <= 6) begin
            push_ev(EV_READ, t, ins[8:6], (op == 6) ? 3'd0 : ins[5:3], op != 6, 16'd0);
            push_ev(EV_EXEC, t + 1, 3'(op - 1), 3'd0, 1'b0, 16'd0);
            push_ev(EV_WB, t + 2, ins[11:9], 3'd0, 1'b1, 16'(model_ret));
            model_ret++;
        end else if (op == 0) begin
            push_ev(EV_WB, t, 3'd0, 3'd0, 1'b0, 16'(model_ret));
            model_ret++;
        end else if (op >= 8) begin
            push_ev(EV_ILL, t, 3'd0, 3'd0, 1'b0, 16'd0);
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send(input logic [15:0] ins);
        int w;
        w = 0;
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && w < 50) begin
            @(negedge ck);
            w++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            model(ins, cyc + 1);
        end
        @(negedge ck);
        instr_valid = 1'b0;
        instr = 16'($urandom);
    endtask

    task automatic take(input int kind, input logic [2:0] a, input logic [2:0] b, input logic c);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'd99);
            return;
        end
        e = exp_q.pop_front();
        chk("ev_kind", 32'(kind), 32'(e.kind));
        chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        chk("ev_a", 32'(a), 32'(e.a));
        chk("ev_b", 32'(b), 32'(e.b));
        chk("ev_c", 32'(c), 32'(e.c));
        if (kind == EV_WB) chk("retired_at_wb", 32'(retired), 32'(e.r));
    endtask

    always @(negedge ck) begin
        if (mon_en) begin
            if (!LOUT && !ROUT) begin
                chk("lsel_quiet", 32'(LSEL), 32'd0);
                chk("rsel_quiet", 32'(RSEL), 32'd0);
            end
            if (!alu_go) chk("aluop_quiet", 32'(alu_op), 32'd0);
            if (!done) chk("wb_quiet", 32'({OSEL, OIN}), 32'd0);
            if (LOUT || ROUT) take(EV_READ, LSEL, RSEL, ROUT);
            if (alu_go) take(EV_EXEC, alu_op, 3'd0, 1'b0);
            if (done || OIN) take(EV_WB, OSEL, 3'd0, OIN);
            if (illegal) begin
                take(EV_ILL, 3'd0, 3'd0, 1'b0);
                chk("ill_no_done", 32'(done), 32'd0);
                chk("ill_ready", 32'(instr_ready), 32'd1);
            end
        end
        if (mon4_en) begin
            chk("u4_quiet", 32'({LSEL4, RSEL4, OSEL4, LOUT4, ROUT4, OIN4, alu_op4, alu_go4,
                                 illegal4, halted4}), 32'd0);
        end
    end

    initial begin
        res = 1'b0;
        instr = 16'd0;
        instr_valid = 1'b0;
        instr4 = 16'd0;
        valid4 = 1'b0;
        repeat (3) @(negedge ck);
        chk("reset_outs", 32'({instr_ready, LSEL, RSEL, OSEL, LOUT, ROUT, OIN, alu_op, alu_go,
                               done, illegal, halted}), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        res = 1'b1;
        @(negedge ck);
        chk("ready_after_reset", 32'(instr_ready), 32'd1);
        mon_en = 1'b1;
        mon4_en = 1'b1;

        fork
            begin
                send(16'h1650);
                send(16'h6F40);
                send(16'h0000);
                send(16'h9000);
                send(16'h9000);
                for (int i = 0; i < 150; i++) begin
                    int op;
                    repeat ($urandom_range(0, 2)) @(negedge ck);
                    op = $urandom_range(0, 14);
                    if (op >= 7) op++;
                    send({4'(op), 12'($urandom)});
                end
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    int w;
                    w = 0;
                    while (!rdy4 && w < 50) begin
                        @(negedge ck);
                        w++;
                    end
                    chk("u4_ready", 32'(rdy4), 32'd1);
                    chk("u4_retired", 32'(ret4), 32'(i % 16));
                    valid4 = 1'b1;
                    @(negedge ck);
                    valid4 = 1'b0;
                end
                repeat (3) @(negedge ck);
                chk("u4_retired_wrap", 32'(ret4), 32'd1);
            end
        join

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge ck);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge ck);
        chk("retired_final", 32'(retired), 32'(16'(model_ret)));

        // HALT ignores a pending valid instruction until reset.
        send(16'h7000);
        instr = 16'h1650;
        instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_ready", 32'(instr_ready), 32'd0);
            chk("halt_quiet", 32'({LOUT, ROUT, OIN, alu_go, done}), 32'd0);
            @(negedge ck);
        end
        res = 1'b0;
        #1;
        chk("halt_cleared", 32'(halted), 32'd0);
        instr_valid = 1'b0;
        @(negedge ck);
        res = 1'b1;
        exp_q.delete();
        model_ret = 0;
        @(negedge ck);
        chk("halt_reset_ready", 32'(instr_ready), 32'd1);
        chk("halt_reset_retired", 32'(retired), 32'd0);

        // Asynchronous reset during EXEC abandons the instruction.
        mon_en = 1'b0;
        send(16'h2248);
        @(negedge ck);
        chk("sub_exec", 32'({alu_go, alu_op}), 32'({1'b1, 3'd1}));
        #2;
        res = 1'b0;
        #1;
        chk("async_outs", 32'({instr_ready, LSEL, RSEL, OSEL, LOUT, ROUT, OIN, alu_op, alu_go,
                               done, illegal, halted}), 32'd0);
        chk("async_retired", 32'(retired), 32'd0);
        exp_q.delete();
        @(negedge ck);
        @(negedge ck);
        res = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge ck);
            chk("post_reset_no_wb", 32'({OIN, done}), 32'd0);
            chk("post_reset_ready", 32'(instr_ready), 32'd1);
        end
        chk("post_reset_retired", 32'(retired), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
